// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// funct3 codes, FSM states and lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    // Byte-enable mask from access size code and byte offset.
    function automatic logic [3:0] be_mask(input logic [1:0] size,
                                           input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate store data across the lanes it may land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                                input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Legal width/sign code for the direction and natural alignment.
    function automatic logic access_ok(input logic we,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !we;
            F3_H:    ok = !off[0];
            F3_HU:   ok = !we && !off[0];
            F3_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU and memory.
// Request channel with valid/ready, read response with rvalid.
interface load_store_unit_if;

    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/load_align.sv
// Load lane select and sign/zero extension.
// Pure combinational; fed by the registered offset and funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    // Pick the addressed byte/half and extend it.
    always_comb begin
        b     = word[{offset, 3'b000} +: 8];
        h     = offset[1] ? word[31:16] : word[15:0];
        value = '0;
        case (funct3)
            F3_B:    value = {{24{b[7]}}, b};
            F3_BU:   value = {24'd0, b};
            F3_H:    value = {{16{h[15]}}, h};
            F3_HU:   value = {16'd0, h};
            F3_W:    value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one bus transaction per memory instruction.
// Stalls the core until the access completes or faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req,
    input  logic                     mem_we,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     stall,
    output logic [31:0]              rdata,
    output logic                     fault,
    load_store_unit_if.master        bus
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] load_val;

    load_align u_align (
        .word   (bus.bus_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .value  (load_val)
    );

    // The core may only advance in DONE or when it is not accessing memory.
    assign stall = mem_req && (state != DONE);

    // Access FSM with registered bus outputs, load data and fault pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            rdata         <= '0;
            fault         <= 1'b0;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_req) begin
                        if (access_ok(mem_we, funct3, addr[1:0])) begin
                            bus.bus_valid <= 1'b1;
                            bus.bus_we    <= mem_we;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_be    <= be_mask(funct3[1:0], addr[1:0]);
                            bus.bus_wdata <= store_lanes(funct3[1:0], wdata);
                            f3_q          <= funct3;
                            off_q         <= addr[1:0];
                            state         <= REQ;
                        end else begin
                            fault <= 1'b1;
                            rdata <= '0;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ready) begin
                        bus.bus_valid <= 1'b0;
                        cnt           <= cnt + 8'd1;
                        state         <= bus.bus_we ? DONE : WAIT;
                    end else if (cnt == LIMIT) begin
                        bus.bus_valid <= 1'b0;
                        fault         <= 1'b1;
                        rdata         <= '0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (bus.bus_rvalid) begin
                        rdata <= load_val;
                        state <= DONE;
                    end else if (cnt == LIMIT) begin
                        fault <= 1'b1;
                        rdata <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
